// File: rtl/gpu_pkg.sv
// Types and constants shared by the triangle setup interpolator and its consumers.
package gpu_pkg;

  localparam int COEF_W    = 24;  // plane coefficient width, two's complement
  localparam int COEF_FRAC = 6;   // fractional bits carried by cx/cy/cs
  localparam int COORD_W   = 12;  // unsigned screen coordinate width

  // Span evaluator sequencing: multiply, sum the row start, then step per pixel.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    RUN  = 2'd3
  } eval_state_t;

  // Plane equation s(x,y) = cx*x + cy*y + cs for one attribute.
  typedef struct packed {
    logic signed [COEF_W-1:0] cx;
    logic signed [COEF_W-1:0] cy;
    logic signed [COEF_W-1:0] cs;
  } span_coef_t;

endpackage

// File: rtl/attr_clamp.sv
// Converts a fixed-point attribute accumulator to an unsigned saturated output.
// Combinational; one instance per attribute channel.
module attr_clamp #(
  parameter int ACCW = 40,
  parameter int FRAC = 6,
  parameter int OUTW = 8
) (
  input  logic signed [ACCW-1:0] acc,
  output logic        [OUTW-1:0] s
);

  logic signed [ACCW-1:0] int_part;

  // Floor to integer, then saturate to [0, 2^OUTW-1].
  always_comb begin
    int_part = acc >>> FRAC;
    if (int_part[ACCW-1]) begin
      s = '0;
    end else if (|int_part[ACCW-2:OUTW]) begin
      s = '1;
    end else begin
      s = int_part[OUTW-1:0];
    end
  end

endmodule

// File: rtl/interp_eval.sv
// Span evaluator: computes the row start of a plane equation once with two
// multiplies, then walks the span left to right adding cx per pixel and emits
// clamped attribute values under valid/ready flow control.
module interp_eval
  import gpu_pkg::*;
#(
  parameter int CW   = COEF_W,
  parameter int FRAC = COEF_FRAC,
  parameter int XW   = COORD_W,
  parameter int OUTW = 8,
  parameter int ACCW = 40
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            span_valid,
  output logic            span_ready,
  input  logic [XW-1:0]   span_x0,
  input  logic [XW-1:0]   span_x1,
  input  logic [XW-1:0]   span_y,
  input  logic [CW-1:0]   span_cx,
  input  logic [CW-1:0]   span_cy,
  input  logic [CW-1:0]   span_cs,
  output logic            pix_valid,
  input  logic            pix_ready,
  output logic [XW-1:0]   pix_x,
  output logic [XW-1:0]   pix_y,
  output logic [OUTW-1:0] pix_s,
  output logic            pix_last
);

  // Signed coefficient times zero-extended coordinate.
  localparam int PW = CW + XW + 1;

  eval_state_t            state_q, state_d;
  span_coef_t             coef_q, coef_d;
  logic [XW-1:0]          x0_q, x0_d;
  logic [XW-1:0]          x1_q, x1_d;
  logic [XW-1:0]          y_q, y_d;
  logic signed [ACCW-1:0] px_q, px_d;
  logic signed [ACCW-1:0] py_q, py_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic                   span_ready_q, span_ready_d;
  logic                   pix_valid_q, pix_valid_d;
  logic                   pix_last_q, pix_last_d;
  logic [XW-1:0]          pix_x_q, pix_x_d;
  logic [XW-1:0]          pix_y_q, pix_y_d;
  logic [OUTW-1:0]        pix_s_q, pix_s_d;

  logic signed [PW-1:0]   prod_x;
  logic signed [PW-1:0]   prod_y;
  logic signed [ACCW-1:0] cs_ext;
  logic signed [ACCW-1:0] cx_ext;
  logic [OUTW-1:0]        s_next;

  // Row-start products and sign-extended coefficients from the latched span.
  always_comb begin
    prod_x = $signed(coef_q.cx) * $signed({1'b0, x0_q});
    prod_y = $signed(coef_q.cy) * $signed({1'b0, y_q});
    cs_ext = {{(ACCW-CW){coef_q.cs[CW-1]}}, coef_q.cs};
    cx_ext = {{(ACCW-CW){coef_q.cx[CW-1]}}, coef_q.cx};
  end

  // The clamped value follows the next accumulator so pix_s is a plain register.
  attr_clamp #(
    .ACCW (ACCW),
    .FRAC (FRAC),
    .OUTW (OUTW)
  ) u_clamp (
    .acc (acc_d),
    .s   (s_next)
  );

  // Next-state and next-output logic for the span sequencer.
  always_comb begin
    state_d     = state_q;
    coef_d      = coef_q;
    x0_d        = x0_q;
    x1_d        = x1_q;
    y_d         = y_q;
    px_d        = px_q;
    py_d        = py_q;
    acc_d       = acc_q;
    pix_valid_d = pix_valid_q;
    pix_last_d  = pix_last_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;

    case (state_q)
      IDLE: begin
        if (span_valid && span_ready_q) begin
          coef_d.cx = span_cx;
          coef_d.cy = span_cy;
          coef_d.cs = span_cs;
          x0_d      = span_x0;
          x1_d      = span_x1;
          y_d       = span_y;
          state_d   = MUL;
        end
      end
      MUL: begin
        px_d    = {{(ACCW-PW){prod_x[PW-1]}}, prod_x};
        py_d    = {{(ACCW-PW){prod_y[PW-1]}}, prod_y};
        state_d = SUM;
      end
      SUM: begin
        acc_d   = cs_ext + px_q + py_q;
        pix_x_d = x0_q;
        pix_y_d = y_q;
        if (x1_q < x0_q) begin
          state_d = IDLE;
        end else begin
          state_d     = RUN;
          pix_valid_d = 1'b1;
          pix_last_d  = (x0_q == x1_q);
        end
      end
      RUN: begin
        if (pix_ready) begin
          if (pix_last_q) begin
            state_d     = IDLE;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
          end else begin
            // Last pixel is detected before incrementing, so x never wraps.
            pix_x_d    = pix_x_q + 1'b1;
            acc_d      = acc_q + cx_ext;
            pix_last_d = (pix_x_d == x1_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    pix_s_d      = s_next;
    span_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset aborts any span in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      coef_q       <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y_q          <= '0;
      px_q         <= '0;
      py_q         <= '0;
      acc_q        <= '0;
      span_ready_q <= 1'b1;
      pix_valid_q  <= 1'b0;
      pix_last_q   <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_s_q      <= '0;
    end else begin
      state_q      <= state_d;
      coef_q       <= coef_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y_q          <= y_d;
      px_q         <= px_d;
      py_q         <= py_d;
      acc_q        <= acc_d;
      span_ready_q <= span_ready_d;
      pix_valid_q  <= pix_valid_d;
      pix_last_q   <= pix_last_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_s_q      <= pix_s_d;
    end
  end

  assign span_ready = span_ready_q;
  assign pix_valid  = pix_valid_q;
  assign pix_last   = pix_last_q;
  assign pix_x      = pix_x_q;
  assign pix_y      = pix_y_q;
  assign pix_s      = pix_s_q;

endmodule

// File: tb/tb_interp_eval.sv
// Scoreboard bench for interp_eval: a driver issues spans and queues the
// expected pixels from a plain-arithmetic plane model; a monitor pops and
// compares on every pixel handshake and checks outputs hold while stalled.
module tb_interp_eval;

  localparam int XW   = 12;
  localparam int CW   = 24;
  localparam int OUTW = 8;

  logic            clk;
  logic            rst_n;
  logic            span_valid;
  logic            span_ready;
  logic [XW-1:0]   span_x0;
  logic [XW-1:0]   span_x1;
  logic [XW-1:0]   span_y;
  logic [CW-1:0]   span_cx;
  logic [CW-1:0]   span_cy;
  logic [CW-1:0]   span_cs;
  logic            pix_valid;
  logic            pix_ready;
  logic [XW-1:0]   pix_x;
  logic [XW-1:0]   pix_y;
  logic [OUTW-1:0] pix_s;
  logic            pix_last;

  interp_eval dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .span_valid (span_valid),
    .span_ready (span_ready),
    .span_x0    (span_x0),
    .span_x1    (span_x1),
    .span_y     (span_y),
    .span_cx    (span_cx),
    .span_cy    (span_cy),
    .span_cs    (span_cs),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_s      (pix_s),
    .pix_last   (pix_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int s;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pop_cnt  = 0;
  int   ready_mode = 0;
  int   pat_idx  = 0;
  bit   pat [6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  // Monitor state for the hold-while-stalled check.
  bit              stall;
  logic [XW-1:0]   sv_x;
  logic [XW-1:0]   sv_y;
  logic [OUTW-1:0] sv_s;
  logic            sv_last;

  function automatic void chk(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Plane value at (x,y), floored to an integer and saturated to 0..255.
  function automatic int model_s(int cx, int cy, int cs, int x, int y);
    longint v;
    longint q;
    v = longint'(cx) * x + longint'(cy) * y + longint'(cs);
    if (v >= 0) q = v / 64;
    else        q = -((-v + 63) / 64);
    if (q < 0)   return 0;
    if (q > 255) return 255;
    return int'(q);
  endfunction

  // Downstream ready generator: always, fixed pattern, or random.
  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1'b1;
        1: begin
          pix_ready = pat[pat_idx % 6];
          pat_idx++;
        end
        default: pix_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compare each handshaken pixel against the scoreboard.
  initial begin
    exp_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk("hold_valid", pix_valid, 1);
          chk("hold_x", pix_x, sv_x);
          chk("hold_y", pix_y, sv_y);
          chk("hold_s", pix_s, sv_s);
          chk("hold_last", pix_last, sv_last);
        end
        if (pix_valid && pix_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pixel: got x=%0d s=%0d, expected no pixel", pix_x, pix_s);
          end else begin
            e = exp_q.pop_front();
            chk("pix_x", pix_x, e.x);
            chk("pix_y", pix_y, e.y);
            chk("pix_s", pix_s, e.s);
            chk("pix_last", pix_last, e.last);
          end
          pop_cnt++;
          stall = 1'b0;
        end else if (pix_valid) begin
          stall   = 1'b1;
          sv_x    = pix_x;
          sv_y    = pix_y;
          sv_s    = pix_s;
          sv_last = pix_last;
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  // Issue one span; called and returns in the posedge+1 phase. With lat set,
  // checks the first-pixel latency (or idle return for an empty span).
  task automatic send_span(input int x0, input int x1, input int y,
                           input int cx, input int cy, input int cs, input bit lat);
    exp_t e;
    int   k;
    for (int x = x0; x <= x1; x++) begin
      e.x    = x;
      e.y    = y;
      e.s    = model_s(cx, cy, cs, x, y);
      e.last = (x == x1);
      exp_q.push_back(e);
    end
    span_x0    = XW'(x0);
    span_x1    = XW'(x1);
    span_y     = XW'(y);
    span_cx    = CW'(cx);
    span_cy    = CW'(cy);
    span_cs    = CW'(cs);
    span_valid = 1'b1;
    k = 0;
    while (!span_ready && k < 500) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!span_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL span_accept_timeout: got span_ready=0, expected 1");
      span_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    // Scramble the inputs to confirm the span was latched at accept.
    span_valid = 1'b0;
    span_x0    = XW'($urandom);
    span_x1    = XW'($urandom);
    span_y     = XW'($urandom);
    span_cx    = CW'($urandom);
    span_cy    = CW'($urandom);
    span_cs    = CW'($urandom);
    if (lat) begin
      @(posedge clk);
      #1;
      chk("lat_t1_valid", pix_valid, 0);
      chk("lat_t1_ready", span_ready, 0);
      @(posedge clk);
      #1;
      if (x1 >= x0) chk("lat_t3_valid", pix_valid, 1);
      else begin
        chk("empty_ready_t3", span_ready, 1);
        chk("empty_no_valid", pix_valid, 0);
      end
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(exp_q.size() == 0 && span_ready && !pix_valid) && k < 5000) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got %0d pending pixels, expected 0", exp_q.size());
    end
  endtask

  // Global bound so the run always ends.
  initial begin
    #5ms;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Directed and random stimulus.
  initial begin
    int base;
    int k;
    int x0;
    int x1;
    int len;
    rst_n      = 1'b0;
    span_valid = 1'b0;
    span_x0    = '0;
    span_x1    = '0;
    span_y     = '0;
    span_cx    = '0;
    span_cy    = '0;
    span_cs    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", pix_valid, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    chk("rst_s", pix_s, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_span_ready", span_ready, 1);

    // Ramp 10..13, span_ready returns at T+7.
    send_span(0, 3, 0, 64, 0, 640, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("ready_low_t6", span_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_high_t7", span_ready, 1);

    // Single pixel driven by cy only.
    send_span(7, 7, 4, 0, 32, 0, 1);
    wait_idle();

    // Upper clamp, then lower clamp with negative constant.
    send_span(0, 4, 0, 128, 0, 16000, 0);
    send_span(0, 2, 0, 64, 0, -320, 0);
    wait_idle();

    // Backpressure pattern.
    ready_mode = 1;
    pat_idx    = 0;
    send_span(0, 3, 0, 64, 0, 640, 0);
    wait_idle();
    ready_mode = 0;

    // Empty span, then a normal one.
    send_span(5, 4, 0, 64, 0, 640, 1);
    send_span(2, 5, 9, 64, 64, 0, 1);
    wait_idle();

    // Reset while the second pixel of a 10-pixel span is presented.
    base = pop_cnt;
    send_span(0, 9, 1, 64, 0, 0, 0);
    k = 0;
    while (pop_cnt < base + 1 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("reset_first_pixel_seen", (pop_cnt >= base + 1) ? 1 : 0, 1);
    @(posedge clk);
    #2;
    chk("pre_reset_valid", pix_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_abort_valid", pix_valid, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_ready", span_ready, 1);
    chk("post_reset_valid", pix_valid, 0);
    send_span(3, 6, 2, -64, 32, 3200, 1);
    wait_idle();

    // Span ending at the maximum coordinate.
    send_span(4090, 4095, 4095, -64, 1, 1000, 0);
    wait_idle();

    // Random spans with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      x0  = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 40)) : int'($urandom_range(0, 4095));
      len = int'($urandom_range(0, 11)) - 1;
      if (x0 == 0 && len < 0) len = 0;
      x1 = x0 + len;
      if (x1 > 4095) x1 = 4095;
      send_span(x0, x1, int'($urandom_range(0, 4095)),
                int'($urandom_range(0, 2048)) - 1024,
                int'($urandom_range(0, 64)) - 32,
                int'($urandom_range(0, 24000)) - 4000, 0);
    end
    wait_idle();
    ready_mode = 0;

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
